imem_ctrl: RTL and testbench
============================

# imem_ctrl

Sequencer for the rotate engine's input pixel buffer (`input_mem`). It accepts a 4x4 BGR tile as twelve 32-bit read-data beats and steers each beat's bytes into buffer locations 0..47. It then drives the B/G/R read addresses in rotated order, so the buffer's registered outputs present one rotated pixel per cycle to the downstream write-back stage. The block sits between the AHB read-data path and `input_mem`.

## Interface
- PARK_BASE, 8'd48, first of four scratch byte addresses used for write-parking; must be ≥ 48 and ≤ 60
- I_IMCTL_HCLK  in  1  clock; the only clock
- I_IMCTL_HRESET  in  1  reset; **one clock; reset is synchronous and active-high**
- I_IMCTL_START  in  1  one-cycle tile start; sampled only in IDLE
- I_IMCTL_ROT  in  2  rotation, captured at START: 0=0°, 1=90° CW, 2=180°, 3=270° CW
- I_IMCTL_MIRROR  in  1  horizontal mirror, captured at START (used only with macro)
- I_IMCTL_RVALID  in  1  read-data beat valid (data goes directly to `input_mem` I_IMEM_RDATA)
- O_IMCTL_RREADY  out  1  beat accept; high exactly in FILL
- O_IMCTL_IN_ADDR0..3  out  8 each  byte write addresses to `input_mem`
- O_IMCTL_OUT_ADDRB/G/R  out  8 each  read addresses to `input_mem`
- O_IMCTL_PIX_VALID  out  1  `input_mem` B/G/R outputs hold a valid rotated pixel
- I_IMCTL_PIX_READY  in  1  downstream accepts pixel
- O_IMCTL_BUSY  out  1  high in FILL or DRAIN
- O_IMCTL_DONE  out  1  one-cycle pulse after the last pixel is accepted

## Operation
- Tile layout: source pixel s = 4r+c, bytes B/G/R at 3s, 3s+1, 3s+2; beat w carries bytes 4w..4w+3 (LSB first).
- FSM states IDLE, FILL, DRAIN.
  - IDLE→FILL on START: capture ROT and MIRROR, clear beat count w. START in any other state is ignored.
  - FILL: a beat is accepted when RVALID is high (RREADY is already high), and w increments. Acceptance of beat 11 →DRAIN.
  - DRAIN: pixel index k runs 0..15; acceptance of k=15 (valid and ready) →IDLE with DONE=1 for one cycle.
- Write addresses (combinational from state, w, and RVALID):
  - In FILL with RVALID: IN_ADDRn = 4w+n.
  - Otherwise: IN_ADDRn = PARK_BASE+n. `input_mem` writes every cycle, so parking is mandatory; parked addresses never collide with read addresses (0..47), so the buffer's bypass path never fires.
- Source index for output (i,j), k=4i+j:
  - ROT0: s=k
  - ROT1: s=4(3−j)+i
  - ROT2: s=15−k
  - ROT3: s=4j+3−i
- OUT_ADDRB/G/R = 3s, 3s+1, 3s+2, all 8-bit, no overflow (max 47). In IDLE/FILL the read addresses are 0/1/2.
- Reset (synchronous) from any state:
  - State goes to IDLE.
  - RREADY=0, PIX_VALID=0, BUSY=0, DONE=0.
  - IN_ADDRn=PARK_BASE+n; OUT_ADDR=0/1/2.
  - A partially filled tile is discarded.

## Timing
- Fill: minimum 12 cycles (RVALID held high). Gaps in RVALID stall w without penalty.
- The first DRAIN cycle presents the address for k=0. PIX_VALID for k rises the cycle after its address is presented, aligned with the `input_mem` output register.
- Read address advances when PIX_VALID=0 or PIX_READY=1. While PIX_VALID=1 and PIX_READY=0, the address holds, so `input_mem` reloads the same bytes and the data stays stable.
- Throughput: 1 pixel per cycle with PIX_READY high. Sixteen pixels occupy DRAIN cycles 2..17, and DONE is asserted in the cycle after the k=15 handshake.
- PIX_VALID drops in the same edge that DONE rises, unless a new tile is in progress. A new START is accepted in the cycle DONE is high (state is already IDLE).

## Configuration
- IMCTL_MIRROR_EN defined: the captured MIRROR=1 replaces j with 3−j before the rotation mapping (mirror is applied to the output coordinates).
- IMCTL_MIRROR_EN undefined: the I_IMCTL_MIRROR port exists but is ignored; the mapping is pure rotation.

## Structure
- Shared package `rotate_pkg`:
  - constants TILE_DIM=4, TILE_PIX=16, TILE_WORDS=12, BYTES_PER_PIX=3
  - ROT_0/ROT_90/ROT_180/ROT_270 encodings
  - FSM state typedef
- One combinational sub-module `imem_rot_addr`: maps (k, rot, mirror) to byte base 3s. `imem_ctrl` instantiates it once.

## Test plan
- ROT=0, 12 back-to-back beats, bytes 0..47 = 0x00..0x2F, READY=1 → pixels k=0..15 give B/G/R = 3k, 3k+1, 3k+2; DONE asserts 29 cycles after START.
- ROT=1, same data → first pixel B=0x24 (s=12), last pixel B=0x09 (s=3); ROT=3 → first pixel B=0x09.
- RVALID toggling 1-0-1, plus READY low for 3 cycles at k=5 → no beat lost; pixel 5 is held stable for 4 cycles; the output sequence is unchanged.
- Outside FILL, write addresses equal 48..51 every cycle; no read address ever exceeds 47; START during FILL is ignored.
- Reset asserted mid-DRAIN at k=7 → next cycle IDLE, all outputs at reset values; a new tile runs correctly from k=0.
- With IMCTL_MIRROR_EN, ROT=0, MIRROR=1 → first pixel B=0x09 (s=3).

Source files
------------

// File: rtl/rotate_pkg.sv
// Shared constants and types for the rotate engine: tile geometry,
// rotation encodings and the input-buffer sequencer state type.
package rotate_pkg;

  localparam int unsigned TILE_DIM      = 4;
  localparam int unsigned TILE_PIX      = 16;
  localparam int unsigned TILE_WORDS    = 12;
  localparam int unsigned BYTES_PER_PIX = 3;

  typedef enum logic [1:0] {
    ROT_0   = 2'd0,
    ROT_90  = 2'd1,
    ROT_180 = 2'd2,
    ROT_270 = 2'd3
  } rot_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DRAIN
  } state_e;

  // Byte address of the B component of source pixel s (3*s, max 45).
  function automatic logic [7:0] pix_base(input logic [3:0] s);
    return {3'b000, s, 1'b0} + {4'b0000, s};
  endfunction

endpackage

// File: rtl/imem_ctrl_if.sv
// Handshake and address bundle between imem_ctrl, the AHB read-data path,
// input_mem and the downstream write-back stage.
interface imem_ctrl_if;

  logic       I_IMCTL_START;
  logic [1:0] I_IMCTL_ROT;
  logic       I_IMCTL_MIRROR;
  logic       I_IMCTL_RVALID;
  logic       O_IMCTL_RREADY;
  logic [7:0] O_IMCTL_IN_ADDR0;
  logic [7:0] O_IMCTL_IN_ADDR1;
  logic [7:0] O_IMCTL_IN_ADDR2;
  logic [7:0] O_IMCTL_IN_ADDR3;
  logic [7:0] O_IMCTL_OUT_ADDRB;
  logic [7:0] O_IMCTL_OUT_ADDRG;
  logic [7:0] O_IMCTL_OUT_ADDRR;
  logic       O_IMCTL_PIX_VALID;
  logic       I_IMCTL_PIX_READY;
  logic       O_IMCTL_BUSY;
  logic       O_IMCTL_DONE;

  modport slave (
    input  I_IMCTL_START, I_IMCTL_ROT, I_IMCTL_MIRROR, I_IMCTL_RVALID,
    input  I_IMCTL_PIX_READY,
    output O_IMCTL_RREADY,
    output O_IMCTL_IN_ADDR0, O_IMCTL_IN_ADDR1, O_IMCTL_IN_ADDR2, O_IMCTL_IN_ADDR3,
    output O_IMCTL_OUT_ADDRB, O_IMCTL_OUT_ADDRG, O_IMCTL_OUT_ADDRR,
    output O_IMCTL_PIX_VALID, O_IMCTL_BUSY, O_IMCTL_DONE
  );

  modport master (
    output I_IMCTL_START, I_IMCTL_ROT, I_IMCTL_MIRROR, I_IMCTL_RVALID,
    output I_IMCTL_PIX_READY,
    input  O_IMCTL_RREADY,
    input  O_IMCTL_IN_ADDR0, O_IMCTL_IN_ADDR1, O_IMCTL_IN_ADDR2, O_IMCTL_IN_ADDR3,
    input  O_IMCTL_OUT_ADDRB, O_IMCTL_OUT_ADDRG, O_IMCTL_OUT_ADDRR,
    input  O_IMCTL_PIX_VALID, O_IMCTL_BUSY, O_IMCTL_DONE
  );

endinterface

// File: rtl/imem_rot_addr.sv
// Maps output pixel index k (row i, column j) plus rotation/mirror to the
// byte base 3*s of the source pixel in input_mem.
module imem_rot_addr
  import rotate_pkg::*;
(
  input  logic [3:0] k_i,
  input  rot_e       rot_i,
  input  logic       mirror_i,
  output logic [7:0] base_o
);

  logic [1:0] row;
  logic [1:0] col;
  logic [3:0] src;

  // For 2-bit fields 3-x is ~x, so every mapping is a bit rearrangement.
  always_comb begin
    row = k_i[3:2];
    col = mirror_i ? ~k_i[1:0] : k_i[1:0];
    unique case (rot_i)
      ROT_0:   src = {row, col};
      ROT_90:  src = {~col, row};
      ROT_180: src = ~{row, col};
      ROT_270: src = {col, ~row};
      default: src = {row, col};
    endcase
    base_o = pix_base(src);
  end

endmodule

// File: rtl/imem_ctrl.sv
// Input pixel buffer sequencer: steers twelve read-data beats into input_mem,
// then drains sixteen rotated pixels. Optional mirror: IMCTL_MIRROR_EN.
module imem_ctrl
  import rotate_pkg::*;
#(
  parameter logic [7:0] PARK_BASE = 8'd48
)
(
  input logic        I_IMCTL_HCLK,
  input logic        I_IMCTL_HRESET,
  imem_ctrl_if.slave bus
);

`ifdef IMCTL_MIRROR_EN
  localparam bit MirrorOn = 1'b1;
`else
  localparam bit MirrorOn = 1'b0;
`endif

  state_e     state_q;
  logic [3:0] w_q;
  logic [4:0] k_q;
  rot_e       rot_q;
  logic       mirror_q;
  logic       pvalid_q;
  logic       done_q;

  logic       stall;
  logic       last_hs;
  logic [3:0] k_sel;
  logic [7:0] base;
  logic [7:0] in_base;

  assign stall   = pvalid_q && !bus.I_IMCTL_PIX_READY;
  assign last_hs = pvalid_q && bus.I_IMCTL_PIX_READY && (k_q == 5'(TILE_PIX));
  // k_q points one past the displayed pixel; a stall re-presents that pixel
  // so the buffer's output register reloads identical bytes.
  assign k_sel   = stall ? 4'(k_q - 5'd1) : k_q[3:0];

  imem_rot_addr u_rot_addr (
    .k_i      (k_sel),
    .rot_i    (rot_q),
    .mirror_i (mirror_q & MirrorOn),
    .base_o   (base)
  );

  always_ff @(posedge I_IMCTL_HCLK) begin
    if (I_IMCTL_HRESET) begin
      state_q  <= ST_IDLE;
      w_q      <= '0;
      k_q      <= '0;
      rot_q    <= ROT_0;
      mirror_q <= 1'b0;
      pvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.I_IMCTL_START) begin
            state_q  <= ST_FILL;
            w_q      <= '0;
            rot_q    <= rot_e'(bus.I_IMCTL_ROT);
            mirror_q <= bus.I_IMCTL_MIRROR;
          end
        end
        ST_FILL: begin
          if (bus.I_IMCTL_RVALID) begin
            w_q <= w_q + 4'd1;
            if (w_q == 4'(TILE_WORDS - 1)) begin
              state_q <= ST_DRAIN;
              k_q     <= '0;
            end
          end
        end
        ST_DRAIN: begin
          if (last_hs) begin
            state_q  <= ST_IDLE;
            pvalid_q <= 1'b0;
            done_q   <= 1'b1;
          end else if (!stall) begin
            pvalid_q <= 1'b1;
            k_q      <= k_q + 5'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    in_base = PARK_BASE;
    if (state_q == ST_FILL && bus.I_IMCTL_RVALID) in_base = {2'b00, w_q, 2'b00};
  end

  assign bus.O_IMCTL_IN_ADDR0 = in_base;
  assign bus.O_IMCTL_IN_ADDR1 = in_base + 8'd1;
  assign bus.O_IMCTL_IN_ADDR2 = in_base + 8'd2;
  assign bus.O_IMCTL_IN_ADDR3 = in_base + 8'd3;

  assign bus.O_IMCTL_OUT_ADDRB = (state_q == ST_DRAIN) ? base         : 8'd0;
  assign bus.O_IMCTL_OUT_ADDRG = (state_q == ST_DRAIN) ? base + 8'd1  : 8'd1;
  assign bus.O_IMCTL_OUT_ADDRR = (state_q == ST_DRAIN) ? base + 8'd2  : 8'd2;

  assign bus.O_IMCTL_RREADY    = (state_q == ST_FILL);
  assign bus.O_IMCTL_BUSY      = (state_q != ST_IDLE);
  assign bus.O_IMCTL_PIX_VALID = pvalid_q;
  assign bus.O_IMCTL_DONE      = done_q;

endmodule

// File: tb/tb_imem_ctrl.sv
// Bench for imem_ctrl: models input_mem, drives random tiles and checks the
// rotated pixel stream against a coordinate-mapping reference.
module tb_imem_ctrl;

`ifdef IMCTL_MIRROR_EN
  localparam bit MIR_EN = 1'b1;
`else
  localparam bit MIR_EN = 1'b0;
`endif
  localparam logic [7:0] PARK = 8'd48;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rdata;
  imem_ctrl_if bus ();

  imem_ctrl #(.PARK_BASE(PARK)) dut (
    .I_IMCTL_HCLK   (clk),
    .I_IMCTL_HRESET (rst),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  // input_mem: four byte write ports every cycle, registered B/G/R reads
  logic [7:0] mem [0:255];
  logic [7:0] mb, mg, mr;
  always @(posedge clk) begin
    mb <= mem[bus.O_IMCTL_OUT_ADDRB];
    mg <= mem[bus.O_IMCTL_OUT_ADDRG];
    mr <= mem[bus.O_IMCTL_OUT_ADDRR];
    mem[bus.O_IMCTL_IN_ADDR0] <= rdata[7:0];
    mem[bus.O_IMCTL_IN_ADDR1] <= rdata[15:8];
    mem[bus.O_IMCTL_IN_ADDR2] <= rdata[23:16];
    mem[bus.O_IMCTL_IN_ADDR3] <= rdata[31:24];
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference: output (i,j) takes source pixel s from the rotation rules
  function automatic int src_of(input int k, input int rot, input int mir);
    int i, j;
    i = k / 4;
    j = k % 4;
    if (MIR_EN && mir != 0) j = 3 - j;
    case (rot)
      0:       return 4 * i + j;
      1:       return 4 * (3 - j) + i;
      2:       return 15 - (4 * i + j);
      default: return 4 * j + 3 - i;
    endcase
  endfunction

  logic [7:0]  tile [0:47];
  logic [23:0] exp_q[$];
  logic [23:0] hold_val;
  bit fill_on, drain_on, hold_on, done_exp, lat_on;
  int w_cnt, pix_cnt, p5_cycles, cyc, start_cyc;
  logic [7:0] first_b, last_b;

  task automatic step();
    logic [31:0] exp_in;
    logic [23:0] pix;
    bit nxt_done, pv, rd;
    @(negedge clk);
    nxt_done = 1'b0;
    pix = {mr, mg, mb};
    pv  = bus.O_IMCTL_PIX_VALID;
    rd  = bus.I_IMCTL_PIX_READY;
    if (fill_on && bus.I_IMCTL_RVALID)
      exp_in = {8'(4*w_cnt+3), 8'(4*w_cnt+2), 8'(4*w_cnt+1), 8'(4*w_cnt)};
    else
      exp_in = {PARK + 8'd3, PARK + 8'd2, PARK + 8'd1, PARK};
    chk("in_addr", {bus.O_IMCTL_IN_ADDR3, bus.O_IMCTL_IN_ADDR2,
                    bus.O_IMCTL_IN_ADDR1, bus.O_IMCTL_IN_ADDR0}, exp_in);
    chk("rready", 32'(bus.O_IMCTL_RREADY), 32'(fill_on));
    chk("busy", 32'(bus.O_IMCTL_BUSY), 32'(fill_on || drain_on));
    chk("done", 32'(bus.O_IMCTL_DONE), 32'(done_exp));
    chk("rd_range", 32'(bus.O_IMCTL_OUT_ADDRB <= 8'd47 && bus.O_IMCTL_OUT_ADDRG <= 8'd47 &&
                        bus.O_IMCTL_OUT_ADDRR <= 8'd47), 32'd1);
    if (!drain_on) begin
      chk("out_idle", {8'h00, bus.O_IMCTL_OUT_ADDRB, bus.O_IMCTL_OUT_ADDRG,
                       bus.O_IMCTL_OUT_ADDRR}, 32'h0000_0102);
      chk("pv_idle", 32'(pv), 32'd0);
    end
    if (hold_on) begin
      chk("hold_pv", 32'(pv), 32'd1);
      chk("hold_pix", 32'(pix), 32'(hold_val));
    end
    if (bus.O_IMCTL_DONE && lat_on) chk("done_lat", 32'(cyc - start_cyc), 32'd29);
    if (drain_on && pv && pix_cnt == 5) p5_cycles++;
    if (drain_on && pv && rd) begin
      if (pix_cnt == 0) first_b = pix[7:0];
      last_b = pix[7:0];
      if (exp_q.size() == 0) chk("extra_pix", 32'(pix), 32'hFFFF_FFFF);
      else chk("pixel", 32'(pix), 32'(exp_q.pop_front()));
      pix_cnt++;
      if (pix_cnt == 16) begin
        drain_on = 1'b0;
        nxt_done = 1'b1;
      end
    end
    hold_on  = drain_on && pv && !rd;
    hold_val = pix;
    if (fill_on && bus.I_IMCTL_RVALID) begin
      w_cnt++;
      if (w_cnt == 12) begin
        fill_on  = 1'b0;
        drain_on = 1'b1;
        pix_cnt  = 0;
      end
    end else if (bus.I_IMCTL_START && !fill_on && !drain_on) begin
      fill_on   = 1'b1;
      w_cnt     = 0;
      start_cyc = cyc + 1;
    end
    if (rst) begin
      fill_on = 1'b0; drain_on = 1'b0; hold_on = 1'b0; nxt_done = 1'b0;
      exp_q.delete();
    end
    done_exp = nxt_done;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // vmode: 0 continuous, 1 random, 2 toggling; rmode: 0 ready, 1 random, 2 stall at pixel 5
  task automatic run_tile(input int rot_v, input int mir_v, input int vmode, input int rmode,
                          input bit seq, input bit sif, input int rst_at,
                          input int ef, input int el);
    int s, n, stalls;
    bit v, tgl;
    for (int b = 0; b < 48; b++) tile[b] = seq ? 8'(b) : 8'($urandom);
    exp_q.delete();
    for (int k = 0; k < 16; k++) begin
      s = src_of(k, rot_v, mir_v);
      exp_q.push_back({tile[3*s+2], tile[3*s+1], tile[3*s]});
    end
    lat_on = (vmode == 0 && rmode == 0 && !sif);
    p5_cycles = 0; stalls = 0; tgl = 1'b1;
    bus.I_IMCTL_START = 1'b1;
    bus.I_IMCTL_ROT = 2'(rot_v);
    bus.I_IMCTL_MIRROR = mir_v[0];
    bus.I_IMCTL_RVALID = 1'b0;
    bus.I_IMCTL_PIX_READY = 1'b1;
    step();
    bus.I_IMCTL_START = 1'b0;
    bus.I_IMCTL_ROT = 2'($urandom);
    bus.I_IMCTL_MIRROR = 1'($urandom);
    n = 0;
    while ((fill_on || drain_on) && n < 400) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = 1'($urandom_range(0, 1));
        default: begin v = tgl; tgl = !tgl; end
      endcase
      bus.I_IMCTL_RVALID = v;
      if (v && fill_on)
        rdata = {tile[4*w_cnt+3], tile[4*w_cnt+2], tile[4*w_cnt+1], tile[4*w_cnt]};
      else
        rdata = $urandom;
      case (rmode)
        0: bus.I_IMCTL_PIX_READY = 1'b1;
        1: bus.I_IMCTL_PIX_READY = 1'($urandom_range(0, 1));
        default: begin
          bus.I_IMCTL_PIX_READY = !(pix_cnt == 5 && bus.O_IMCTL_PIX_VALID && stalls < 3);
          if (!bus.I_IMCTL_PIX_READY) stalls++;
        end
      endcase
      bus.I_IMCTL_START = sif && fill_on && w_cnt == 5;
      rst = (rst_at >= 0 && drain_on && pix_cnt == rst_at);
      step();
      n++;
      if (rst) begin
        rst = 1'b0;
        bus.I_IMCTL_START = 1'b0;
        bus.I_IMCTL_RVALID = 1'b0;
        step();
        return;
      end
    end
    bus.I_IMCTL_START = 1'b0;
    bus.I_IMCTL_RVALID = 1'b0;
    rdata = $urandom;
    chk("timeout", 32'(fill_on || drain_on), 32'd0);
    step();
    if (rmode == 2) chk("p5_hold", 32'(p5_cycles), 32'd4);
    if (ef >= 0) chk("first_b", 32'(first_b), 32'(ef));
    if (el >= 0) chk("last_b", 32'(last_b), 32'(el));
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    rst = 1'b1;
    rdata = '0;
    bus.I_IMCTL_START = 1'b0;
    bus.I_IMCTL_ROT = 2'd0;
    bus.I_IMCTL_MIRROR = 1'b0;
    bus.I_IMCTL_RVALID = 1'b0;
    bus.I_IMCTL_PIX_READY = 1'b1;
    fill_on = 0; drain_on = 0; hold_on = 0; done_exp = 0; lat_on = 0;
    w_cnt = 0; pix_cnt = 0; p5_cycles = 0; cyc = 0; start_cyc = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    step();
    //        rot mir vm rm seq sif rst  first last
    run_tile(0,  0,  0, 0, 1,  0,  -1,  8'h00, 8'h2D);
    run_tile(1,  0,  0, 0, 1,  0,  -1,  8'h24, 8'h09);
    run_tile(3,  0,  0, 0, 1,  0,  -1,  8'h09, 8'h24);
    run_tile(2,  0,  2, 2, 0,  0,  -1,  -1,    -1);
    run_tile(1,  1,  1, 1, 0,  1,  -1,  -1,    -1);
    run_tile(3,  0,  1, 1, 0,  0,   7,  -1,    -1);
    run_tile(0,  0,  0, 0, 1,  0,  -1,  8'h00, 8'h2D);
    if (MIR_EN) run_tile(0, 1, 0, 0, 1, 0, -1, 8'h09, -1);
    for (int t = 0; t < 6; t++)
      run_tile(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
               int'($urandom_range(0, 2)), int'($urandom_range(0, 1)), 0, 0, -1, -1, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
